// File: rtl/vram_arbiter_pkg.sv
// Shared video-RAM arbiter definitions: widths, sizes, CPU FSM encoding and
// the tag carried alongside each RAM read.
package vram_arbiter_pkg;

   localparam int unsigned ADDR_W       = 13;
   localparam int unsigned DATA_W       = 8;
   localparam int unsigned VRAM_SIZE    = 7168;
   localparam int unsigned STARVE_LIMIT = 64;

   // CPU access sequencer states
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } cpu_state_e;

   // Who a returning read byte belongs to
   typedef enum logic {
      OwnVid = 1'b0,
      OwnCpu = 1'b1
   } owner_e;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } ret_tag_t;

   // True when a byte address maps onto populated VRAM
   function automatic logic in_vram(input logic [31:0] addr, input int unsigned size);
      return addr < size;
   endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the video fetch, CPU access and RAM port signals around the arbiter.
interface vram_arbiter_if #(
   parameter int unsigned ADDR_W = vram_arbiter_pkg::ADDR_W,
   parameter int unsigned DATA_W = vram_arbiter_pkg::DATA_W
);

   // Video scanout fetch
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_data;
   logic              vid_valid;

   // CPU access
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_starved;

   // Single-port synchronous RAM, 1-cycle read latency
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   // Arbiter side
   modport slave (
      input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      output vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_starved,
      output ram_addr, ram_we, ram_wdata
   );

   // Requesters plus RAM model side
   modport master (
      output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
      input  vid_data, vid_valid, cpu_ack, cpu_rdata, cpu_starved,
      input  ram_addr, ram_we, ram_wdata
   );

endinterface

// File: rtl/vram_return_pipe.sv
// Two-stage tag pipeline that follows each RAM read so the returning byte can
// be steered to video or CPU when it comes back from the RAM.
module vram_return_pipe
   import vram_arbiter_pkg::*;
(
   input  logic     clk,
   input  logic     rst_n,
   input  ret_tag_t launch,
   output ret_tag_t retire
);

   ret_tag_t stage1_q;
   ret_tag_t stage2_q;

   // Stage 1 lines up with the RAM address, stage 2 with the RAM read data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage1_q <= '0;
         stage2_q <= '0;
      end else begin
         stage1_q <= launch;
         stage2_q <= stage1_q;
      end
   end

   assign retire = stage2_q;

endmodule

// File: rtl/vram_arbiter.sv
// Video RAM arbiter: one RAM access per cycle, video scanout fetches have
// strict priority, CPU accesses are sequenced by a small FSM and tracked for
// starvation.
module vram_arbiter #(
   parameter int unsigned ADDR_W       = vram_arbiter_pkg::ADDR_W,
   parameter int unsigned DATA_W       = vram_arbiter_pkg::DATA_W,
   parameter int unsigned VRAM_SIZE    = vram_arbiter_pkg::VRAM_SIZE,
   parameter int unsigned STARVE_LIMIT = vram_arbiter_pkg::STARVE_LIMIT
) (
   input logic           clk_25mhz,
   input logic           reset_n,
   vram_arbiter_if.slave bus
);

   import vram_arbiter_pkg::*;

   localparam int unsigned     CntW   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIMIT);

   cpu_state_e        state_q;
   cpu_state_e        state_d;
   logic              armed_q;
   logic              vid_grant;
   logic              cpu_grant;
   logic              cpu_in_range;
   logic              wr_done;
   logic              cpu_we_q;
   logic              cpu_oor_q;

   logic [ADDR_W-1:0] ram_addr_q;
   logic              ram_we_q;
   logic [DATA_W-1:0] ram_wdata_q;

   logic [CntW-1:0]   wait_cnt_q;
   logic [CntW-1:0]   wait_cnt_d;
   logic              starved_q;

   ret_tag_t          launch;
   ret_tag_t          retire;

   logic              vid_valid_q;
   logic [DATA_W-1:0] vid_data_q;
   logic              cpu_ack_q;
   logic [DATA_W-1:0] cpu_rdata_q;

   // Grant decode: video wins any collision, CPU only starts from idle
   always_comb begin
      vid_grant    = armed_q & bus.vid_req;
      cpu_grant    = armed_q & (state_q == StIdle) & bus.cpu_req & ~bus.vid_req;
      cpu_in_range = in_vram(32'(bus.cpu_addr), VRAM_SIZE);
      launch       = '0;
      if (vid_grant) begin
         launch.valid = 1'b1;
         launch.owner = OwnVid;
      end else if (cpu_grant && !bus.cpu_we) begin
         // Out-of-range reads still ride the pipe so the ack keeps read timing
         launch.valid = 1'b1;
         launch.owner = OwnCpu;
      end
   end

   // Suppress grants on the first edge after reset release
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         armed_q <= 1'b0;
      end else begin
         armed_q <= 1'b1;
      end
   end

   // CPU FSM state register
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // CPU FSM next state; writes finish from ISSUE, reads wait for the pipe
   always_comb begin
      state_d = state_q;
      wr_done = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cpu_grant) begin
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (cpu_we_q) begin
               state_d = StIdle;
               wr_done = 1'b1;
            end else begin
               state_d = StWait;
            end
         end
         StWait: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Capture the granted CPU access attributes
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         cpu_we_q  <= 1'b0;
         cpu_oor_q <= 1'b0;
      end else if (cpu_grant) begin
         cpu_we_q  <= bus.cpu_we;
         cpu_oor_q <= ~cpu_in_range;
      end
   end

   // RAM port: address holds when idle, write enable is a single-cycle pulse
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
      end else begin
         ram_we_q <= 1'b0;
         if (vid_grant) begin
            ram_addr_q <= bus.vid_addr;
         end else if (cpu_grant && cpu_in_range) begin
            ram_addr_q <= bus.cpu_addr;
            ram_we_q   <= bus.cpu_we;
            if (bus.cpu_we) begin
               ram_wdata_q <= bus.cpu_wdata;
            end
         end
      end
   end

   // Starvation counter next value: counts refused idle requests, saturates
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (cpu_grant) begin
         wait_cnt_d = '0;
      end else if (armed_q && (state_q == StIdle) && bus.cpu_req && (wait_cnt_q != CntMax)) begin
         wait_cnt_d = wait_cnt_q + CntW'(1);
      end
   end

   // Starvation counter and sticky flag
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         wait_cnt_q <= '0;
         starved_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         if (wait_cnt_d == CntMax) begin
            starved_q <= 1'b1;
         end
      end
   end

   vram_return_pipe u_return_pipe (
      .clk    (clk_25mhz),
      .rst_n  (reset_n),
      .launch (launch),
      .retire (retire)
   );

   // Return stage: steer RAM read data to its owner; data holds between strobes
   always_ff @(posedge clk_25mhz or negedge reset_n) begin
      if (!reset_n) begin
         vid_valid_q <= 1'b0;
         vid_data_q  <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         vid_valid_q <= 1'b0;
         cpu_ack_q   <= wr_done;
         if (retire.valid) begin
            if (retire.owner == OwnVid) begin
               vid_valid_q <= 1'b1;
               vid_data_q  <= bus.ram_rdata;
            end else begin
               cpu_ack_q   <= 1'b1;
               cpu_rdata_q <= cpu_oor_q ? '0 : bus.ram_rdata;
            end
         end
      end
   end

   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_wdata   = ram_wdata_q;
   assign bus.vid_valid   = vid_valid_q;
   assign bus.vid_data    = vid_data_q;
   assign bus.cpu_ack     = cpu_ack_q;
   assign bus.cpu_rdata   = cpu_rdata_q;
   assign bus.cpu_starved = starved_q;

endmodule
